dm_access_unit: RTL
===================

DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port req_valid, input, 1, CPU access request valid.
REQ-006 Port req_ready, output, 1, unit can accept a request.
REQ-007 Port req_we, input, 1; 1 means store, 0 means load.
REQ-008 Port req_size, input, 2, access size: 0=byte, 1=half, 2=word, 3=double (double legal only when DATA_W=64).
REQ-009 Port req_unsigned, input, 1, zero-extend load data when 1, sign-extend when 0.
REQ-010 Port req_addr, input, ADDR_W, byte address.
REQ-011 Port req_wdata, input, DATA_W, store data, right-aligned.
REQ-012 Ports mem_req (output, 1), mem_we (output, 1), mem_be (output, DATA_W/8), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_gnt (input, 1): memory request channel.
REQ-013 Ports mem_rvalid (input, 1) and mem_rdata (input, DATA_W): memory read-return channel.
REQ-014 Ports resp_valid (output, 1), resp_rdata (output, DATA_W), resp_exc (output, 1): completion, extended load data, and misalignment flag.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE with req_valid=1: latch the request, then go to ISSUE; or go to DONE if misaligned and DM_ALIGN_EXC_EN is defined.
REQ-017 ISSUE SHALL hold mem_req=1 with stable mem_* outputs until mem_gnt=1; on grant, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-018 WAIT SHALL capture mem_rdata on the cycle mem_rvalid=1 and then go to DONE; mem_rvalid SHALL be ignored in every other state.
REQ-019 DONE SHALL assert resp_valid for exactly one cycle and then return to IDLE; the best-case latency from accept to resp_valid is 2 cycles for stores and 3 cycles for loads.
REQ-020 The byte offset SHALL be off = req_addr[log2(DATA_W/8)-1:0]. mem_addr SHALL equal req_addr with the off bits cleared.
REQ-021 mem_be SHALL be ((1<<(1<<req_size))-1) << off, truncated to DATA_W/8 bits. mem_wdata SHALL be req_wdata << (8*off).
REQ-022 Load data SHALL be computed as (mem_rdata >> 8*off), then sign- or zero-extended from the access size to DATA_W; for size equal to DATA_W no extension is applied.
REQ-023 resp_rdata SHALL hold its last value outside DONE and SHALL be 0 for stores and for excepted accesses.
REQ-024 An access is misaligned when off is not a multiple of the size in bytes, or when size=3 with DATA_W=32.

Reset
REQ-025 reset SHALL force IDLE, req_ready=1 on the next cycle, and mem_req=0, resp_valid=0, resp_exc=0, resp_rdata=0, mem_be=0.
REQ-026 A reset asserted mid-access SHALL abandon the access with no response; a mem_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-027 With DM_ALIGN_EXC_EN defined, a misaligned request SHALL issue no memory transaction and SHALL complete via DONE with resp_exc=1.
REQ-028 With DM_ALIGN_EXC_EN undefined, the low address bits SHALL be masked down to the size alignment (and size 3 with DATA_W=32 treated as size 2), resp_exc SHALL be tied to 0, and the access SHALL proceed normally.

Structure
REQ-029 Package dm_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum.
REQ-030 One combinational sub-module, dm_lane_shifter, SHALL perform the byte-enable, write-shift and load-extract/extend logic; the FSM and registers SHALL stay in dm_access_unit.

Verification
REQ-031 DATA_W=32, sb addr 0x13, wdata 0x000000AB -> mem_be=4'b1000, mem_wdata=0xAB000000, mem_addr=0x10, resp_valid 2 cycles after accept with mem_gnt=1 immediately.
REQ-032 DATA_W=32, lh addr 0x22, mem_rdata 0x8001_1234 -> resp_rdata=0xFFFF8001; with lhu -> 0x00008001.
REQ-033 DATA_W=64, ld addr 0x08, mem_gnt delayed 3 cycles, rvalid 2 cycles after grant -> mem_req held 4 cycles with stable outputs, resp_rdata=mem_rdata, req_ready=0 throughout.
REQ-034 DM_ALIGN_EXC_EN defined, lw addr 0x06 -> mem_req never asserted, resp_exc=1, resp_rdata=0; undefined -> mem_addr=0x04, resp_exc=0.
REQ-035 reset asserted in WAIT, followed by mem_rvalid=1 -> no resp_valid, req_ready=1 the cycle after reset.
REQ-036 Spurious mem_rvalid=1 in IDLE -> no state change and no resp_valid.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit: size encodings,
// FSM state type and the per-size alignment mask helper.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } dm_state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_shifter.sv
// Combinational lane steering: byte enables, store-data shift and
// load-data extract with sign/zero extension.
module dm_lane_shifter import dm_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [NB-1:0]     o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [7:0]        w_lanes;
  logic [DATA_W-1:0] w_rsh;
  logic [DATA_W-1:0] w_keep;
  logic              w_sign;
  logic              w_fill;

  always_comb begin
    case (i_size)
      SZ_B:    w_lanes = 8'h01;
      SZ_H:    w_lanes = 8'h03;
      SZ_W:    w_lanes = 8'h0F;
      default: w_lanes = 8'hFF;
    endcase
    o_be = NB'(w_lanes) << i_off;
  end

  assign o_wdata = i_wdata << {i_off, 3'b000};

  // w_keep marks the bits that belong to the access; the rest take the fill.
  always_comb begin
    w_rsh  = i_rdata >> {i_off, 3'b000};
    w_keep = '1;
    case (i_size)
      SZ_B: begin
        w_keep = w_keep >> (DATA_W - 8);
        w_sign = w_rsh[7];
      end
      SZ_H: begin
        w_keep = w_keep >> (DATA_W - 16);
        w_sign = w_rsh[15];
      end
      SZ_W: begin
        w_keep = w_keep >> (DATA_W - 32);
        w_sign = w_rsh[31];
      end
      default: w_sign = w_rsh[DATA_W-1];
    endcase
    w_fill  = w_sign & ~i_unsigned;
    o_rdata = (w_rsh & w_keep) | ({DATA_W{w_fill}} & ~w_keep);
  end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store access unit between a CPU request port and a grant/rvalid memory.
// Define DM_ALIGN_EXC_EN to trap misaligned accesses instead of masking them.
module dm_access_unit import dm_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_exc
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  dm_state_e         r_state, w_next;
  logic              r_we;
  logic              r_unsigned;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_size_eff;
  logic [ADDR_W-1:0] w_addr_eff;
  logic              w_exc;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata_ext;

`ifdef DM_ALIGN_EXC_EN
  logic r_exc;
  logic w_misalign;

  assign w_misalign = ((req_addr[2:0] & align_mask(req_size)) != 3'b000) ||
                      (req_size == SZ_D && DATA_W == 32);
  assign w_size_eff = req_size;
  assign w_addr_eff = req_addr;
  assign w_exc      = w_misalign;
`else
  // Doubles on a 32-bit bus degrade to words before the address is masked.
  assign w_size_eff = (req_size == SZ_D && DATA_W == 32) ? SZ_W : req_size;
  assign w_addr_eff = req_addr & ~ADDR_W'(align_mask(w_size_eff));
  assign w_exc      = 1'b0;
`endif

  dm_lane_shifter #(.DATA_W(DATA_W)) u_lane_shifter (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_off      (r_addr[OFF_W-1:0]),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid)  w_next = w_exc ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (mem_gnt)    w_next = r_we ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (mem_rvalid) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    mem_req    = (r_state == ST_ISSUE);
    mem_we     = mem_req & r_we;
    mem_be     = mem_req ? w_be : '0;
    mem_addr   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    mem_wdata  = w_wdata;
    resp_valid = (r_state == ST_DONE);
    resp_rdata = r_rdata;
`ifdef DM_ALIGN_EXC_EN
    resp_exc   = (r_state == ST_DONE) & r_exc;
`else
    resp_exc   = 1'b0;
`endif
  end

  // resp_rdata only changes on edges entering DONE, so it holds elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_B;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
`ifdef DM_ALIGN_EXC_EN
      r_exc      <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_size     <= w_size_eff;
        r_addr     <= w_addr_eff;
        r_wdata    <= req_wdata;
`ifdef DM_ALIGN_EXC_EN
        r_exc      <= w_exc;
`endif
        if (w_exc) r_rdata <= '0;
      end
      if (r_state == ST_ISSUE && mem_gnt && r_we) r_rdata <= '0;
      if (r_state == ST_WAIT && mem_rvalid)       r_rdata <= w_rdata_ext;
    end
  end

endmodule
